// File: rtl/symbol_frame_check_if.sv
// Symbol stream in / status records out for symbol_frame_check.
// master drives symbols and stat_ready; slave is the frame checker itself.
interface symbol_frame_check_if;
    logic        valid_in;
    logic [6:0]  data_in;
    logic        sop_in;
    logic        eop_in;
    logic        stat_valid;
    logic        stat_ready;
    logic [15:0] stat_len;
    logic [3:0]  stat_err;
    logic        stat_ovf;
    logic [7:0]  orphan_cnt;

    modport master (
        output valid_in, data_in, sop_in, eop_in, stat_ready,
        input  stat_valid, stat_len, stat_err, stat_ovf, orphan_cnt
    );

    modport slave (
        input  valid_in, data_in, sop_in, eop_in, stat_ready,
        output stat_valid, stat_len, stat_err, stat_ovf, orphan_cnt
    );
endinterface

// File: rtl/symbol_frame_check.sv
// Frames sop/eop symbol packets, checks 7-bit sum/length/truncation and queues one record per packet.
// Record visible 1 cycle after completion via FWFT FIFO; no input back-pressure, full FIFO drops records (sticky stat_ovf).
module symbol_frame_check #(
    parameter int MAX_LEN    = 1024,
    parameter int STAT_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    symbol_frame_check_if.slave bus
);
    localparam int          PW         = $clog2(STAT_DEPTH);
    localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_len, w_len_nxt, w_len_inc, w_rec_len;
    logic [6:0]  r_sum, w_sum_nxt, w_rec_sum;
    logic        w_push, w_trunc, w_orphan;
    logic [2:0]  w_rec_err;

    logic [18:0] r_mem [STAT_DEPTH];
    logic [PW:0] r_wptr, r_rptr;
    logic [18:0] w_head;
    logic        w_empty, w_full, w_pop, w_wr;
    logic        r_ovf;
    logic [7:0]  r_orphan;

    assign w_len_inc = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_sum_nxt   = r_sum;
        w_push      = 1'b0;
        w_trunc     = 1'b0;
        w_orphan    = 1'b0;
        w_rec_len   = r_len;
        w_rec_sum   = r_sum;
        if (bus.valid_in) begin
            case (r_state)
                IDLE: begin
                    if (bus.sop_in) begin
                        w_len_nxt = 16'd1;
                        w_sum_nxt = bus.data_in;
                        if (bus.eop_in) begin
                            w_push    = 1'b1;
                            w_rec_len = 16'd1;
                            w_rec_sum = bus.data_in;
                        end else begin
                            w_state_nxt = IN_PKT;
                        end
                    end else begin
                        w_orphan = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (!bus.sop_in) begin
                        w_len_nxt = w_len_inc;
                        w_sum_nxt = r_sum + bus.data_in;
                        if (bus.eop_in) begin
                            w_push      = 1'b1;
                            w_rec_len   = w_len_inc;
                            w_rec_sum   = r_sum + bus.data_in;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        // A fresh sop cuts the open packet short; the record carries only the symbols already seen.
                        w_push  = 1'b1;
                        w_trunc = 1'b1;
                        if (bus.eop_in) begin
                            w_orphan    = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_len_nxt = 16'd1;
                            w_sum_nxt = bus.data_in;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_rec_err = {w_trunc, (w_rec_len > LP_MAX_LEN), (w_rec_sum != 7'd0)};

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_pop   = !w_empty && bus.stat_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[PW-1:0]] <= {w_rec_len, w_rec_err};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_len    <= 16'd0;
            r_sum    <= 7'd0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_ovf    <= 1'b0;
            r_orphan <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_sum   <= w_sum_nxt;
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_wr) r_ovf <= 1'b1;
            if (w_orphan && r_orphan != 8'hFF) r_orphan <= r_orphan + 8'd1;
        end
    end

    assign bus.stat_valid = !w_empty;
    assign bus.stat_len   = w_empty ? 16'd0 : w_head[18:3];
    assign bus.stat_err   = w_empty ? 4'd0 : {1'b0, w_head[2:0]};
    assign bus.stat_ovf   = r_ovf;
    assign bus.orphan_cnt = r_orphan;
endmodule

// File: tb/tb_symbol_frame_check.sv
// Directed bench for symbol_frame_check with MAX_LEN=4, STAT_DEPTH=4.
module tb_symbol_frame_check;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    symbol_frame_check_if bus ();

    symbol_frame_check #(.MAX_LEN(4), .STAT_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sym(input logic [6:0] d, input logic s, input logic e);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        bus.sop_in   = s;
        bus.eop_in   = e;
        @(posedge clk);
        #1;
        bus.valid_in = 1'b0;
        bus.sop_in   = 1'b0;
        bus.eop_in   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head(input string tag, input logic [15:0] len, input logic [3:0] err);
        check({tag, "_vld"}, 32'(bus.stat_valid), 32'd1);
        check({tag, "_len"}, 32'(bus.stat_len), 32'(len));
        check({tag, "_err"}, 32'(bus.stat_err), 32'(err));
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.valid_in   = 1'b0;
        bus.data_in    = 7'd0;
        bus.sop_in     = 1'b0;
        bus.eop_in     = 1'b0;
        bus.stat_ready = 1'b1;
        #12;
        check("rst_vld", 32'(bus.stat_valid), 32'd0);
        check("rst_len", 32'(bus.stat_len), 32'd0);
        check("rst_err", 32'(bus.stat_err), 32'd0);
        check("rst_ovf", 32'(bus.stat_ovf), 32'd0);
        check("rst_orph", 32'(bus.orphan_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Good packet, sum 0x80 wraps to 0
        sym(7'h10, 1, 0);
        sym(7'h20, 0, 0);
        check("good_pre_vld", 32'(bus.stat_valid), 32'd0);
        sym(7'h50, 0, 1);
        head("good", 16'd3, 4'h0);
        tick();
        check("good_drained", 32'(bus.stat_valid), 32'd0);

        // Single-symbol bad checksum, then 3-symbol bad checksum
        sym(7'h05, 1, 1);
        head("single", 16'd1, 4'h1);
        tick();
        sym(7'h01, 1, 0);
        sym(7'h01, 0, 0);
        sym(7'h01, 0, 1);
        head("csum3", 16'd3, 4'h1);
        tick();

        // Truncation with consumer stalled
        bus.stat_ready = 1'b0;
        sym(7'h7F, 1, 0);
        sym(7'h01, 0, 0);
        sym(7'h00, 1, 0);
        head("trunc1", 16'd2, 4'h4);
        sym(7'h00, 0, 1);
        head("trunc1_hold", 16'd2, 4'h4);
        bus.stat_ready = 1'b1;
        tick();
        head("trunc2", 16'd2, 4'h0);
        tick();
        check("trunc_drained", 32'(bus.stat_valid), 32'd0);

        // Orphans in IDLE, eop without sop included
        sym(7'h11, 0, 0);
        sym(7'h22, 0, 1);
        sym(7'h33, 0, 0);
        check("orph_cnt", 32'(bus.orphan_cnt), 32'd3);
        check("orph_norec", 32'(bus.stat_valid), 32'd0);

        // Too long (5 > 4), then exactly MAX_LEN
        sym(7'h40, 1, 0);
        for (int i = 0; i < 3; i++) sym(7'h00, 0, 0);
        sym(7'h40, 0, 1);
        head("toolong", 16'd5, 4'h2);
        tick();
        sym(7'h20, 1, 0);
        sym(7'h20, 0, 0);
        sym(7'h20, 0, 0);
        sym(7'h20, 0, 1);
        head("maxlen", 16'd4, 4'h0);
        tick();

        // sop&eop inside a packet: truncated record plus an orphan
        sym(7'h01, 1, 0);
        sym(7'h02, 1, 1);
        head("sopeop", 16'd1, 4'h5);
        check("sopeop_orph", 32'(bus.orphan_cnt), 32'd4);
        tick();
        check("sopeop_idle", 32'(bus.stat_valid), 32'd0);

        // FIFO full: four records held, fifth dropped
        bus.stat_ready = 1'b0;
        sym(7'h00, 1, 1);
        sym(7'h40, 1, 0);
        sym(7'h40, 0, 1);
        sym(7'h10, 1, 0);
        sym(7'h20, 0, 0);
        sym(7'h50, 0, 1);
        for (int i = 0; i < 3; i++) sym(7'h20, (i == 0), 0);
        sym(7'h20, 0, 1);
        check("full_noovf", 32'(bus.stat_ovf), 32'd0);
        head("full_head", 16'd1, 4'h0);
        sym(7'h00, 1, 1);
        check("full_ovf", 32'(bus.stat_ovf), 32'd1);
        head("full_head2", 16'd1, 4'h0);
        // Push coinciding with a pop on a full FIFO is kept
        bus.stat_ready = 1'b1;
        sym(7'h05, 1, 1);
        head("drain2", 16'd2, 4'h0);
        tick();
        head("drain3", 16'd3, 4'h0);
        tick();
        head("drain4", 16'd4, 4'h0);
        tick();
        head("drain_new", 16'd1, 4'h1);
        tick();
        check("drain_empty", 32'(bus.stat_valid), 32'd0);
        check("ovf_sticky", 32'(bus.stat_ovf), 32'd1);

        // Async reset mid-packet with a record queued
        bus.stat_ready = 1'b0;
        sym(7'h00, 1, 1);
        sym(7'h11, 1, 0);
        sym(7'h22, 0, 0);
        check("pre_rst_vld", 32'(bus.stat_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_vld", 32'(bus.stat_valid), 32'd0);
        check("arst_len", 32'(bus.stat_len), 32'd0);
        check("arst_err", 32'(bus.stat_err), 32'd0);
        check("arst_ovf", 32'(bus.stat_ovf), 32'd0);
        check("arst_orph", 32'(bus.orphan_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.stat_ready = 1'b1;
        tick();
        check("post_rst_vld", 32'(bus.stat_valid), 32'd0);
        sym(7'h00, 0, 1);
        check("post_rst_orph", 32'(bus.orphan_cnt), 32'd1);
        check("post_rst_norec", 32'(bus.stat_valid), 32'd0);
        sym(7'h03, 1, 1);
        head("post_rst_pkt", 16'd1, 4'h1);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/symbol_frame_check.md
SYMBOL_FRAME_CHECK -- requirements
Module: symbol_frame_check

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- MAX_LEN, 1024, largest legal packet length in symbols, range 1..65535.
- STAT_DEPTH, 4, status FIFO depth in records, power of two, minimum 2.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on the rising edge.
- rst, in, 1, reset; asynchronous and active-high.
- valid_in, in, 1, symbol qualifier; no back-pressure, so a symbol is accepted every cycle valid_in=1.
- data_in, in, 7, symbol.
- sop_in, in, 1, first symbol of a packet; qualified by valid_in.
- eop_in, in, 1, last symbol of a packet; qualified by valid_in.
- stat_valid, out, 1, a status record is at the FIFO head.
- stat_ready, in, 1, consumer pops the head when stat_valid&stat_ready.
- stat_len, out, 16, head record packet length in symbols.
- stat_err, out, 4, head record error flags: [0] csum, [1] too_long, [2] trunc, [3] reserved, always 0.
- stat_ovf, out, 1, sticky flag: a record was dropped because the FIFO was full.
- orphan_cnt, out, 8, count of discarded symbols; saturates at 255.

Function
REQ-003 The frame FSM SHALL have two states, IDLE and IN_PKT; len is a 16-bit register and sum is a 7-bit register.
REQ-004 In IDLE, valid&sop&!eop SHALL set len=1 and sum=data_in, and go to IN_PKT.
REQ-005 In IDLE, valid&sop&eop SHALL complete a 1-symbol packet: len=1, sum=data_in. The FSM stays in IDLE.
REQ-006 In IDLE, valid&!sop SHALL discard the symbol and increment orphan_cnt. This applies whatever the value of eop.
REQ-007 In IN_PKT, valid&!sop&!eop SHALL add 1 to len, saturating at 65535, and update sum = sum + data_in mod 128.
REQ-008 In IN_PKT, valid&!sop&eop SHALL complete the packet, including this symbol in len and sum, and go to IDLE.
REQ-009 In IN_PKT, valid&sop&!eop SHALL do three things:
- complete the current packet with trunc=1, not counting the new symbol;
- start a new packet with len=1 and sum=data_in;
- stay in IN_PKT.
REQ-010 In IN_PKT, valid&sop&eop SHALL do three things:
- complete the current packet with trunc=1;
- discard the new symbol and increment orphan_cnt;
- go to IDLE.
REQ-011 In any state, valid_in=0 SHALL leave the FSM, len and sum unchanged.
REQ-012 On completion, the block SHALL form the record fields as follows:
- csum = (final 7-bit sum != 0);
- too_long = (final len > MAX_LEN), using the saturated len;
- stat_len = final len.
REQ-013 A completed record SHALL be pushed into the status FIFO in the completion cycle and be visible on the stat_* outputs the next cycle, giving 1-cycle latency. The FIFO is first-word-fall-through.
REQ-014 stat_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-015 stat_len and stat_err SHALL hold steady while stat_valid=1 and stat_ready=0.
REQ-016 If the FIFO is full at a push, the record SHALL be dropped and stat_ovf set.
- Exception: if a pop occurs in the same cycle, the push SHALL be accepted.
REQ-017 A simultaneous push and pop on an empty FIFO SHALL NOT pop. The pushed record appears next cycle.
REQ-018 stat_ovf SHALL stay set until reset. orphan_cnt SHALL stay at 255 once reached.
REQ-019 The FIFO read and write pointers SHALL wrap modulo STAT_DEPTH. A full flag or extra pointer bit SHALL distinguish full from empty.

Reset
REQ-020 When rst is asserted, the block SHALL immediately set:
- FSM to IDLE;
- len=0 and sum=0;
- FIFO empty;
- stat_valid=0, stat_ovf=0, orphan_cnt=0;
- stat_len=0 and stat_err=0.
REQ-021 Reset asserted mid-packet SHALL abandon the packet without emitting a record.
REQ-022 After rst deasserts, the first accepted sop SHALL start a packet normally.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- Good packet: symbols 0x10, 0x20, 0x50 (sum 0x80 = 0 mod 128) with sop on the first and eop on the last, stat_ready=1 -> one cycle after eop, stat_valid=1, stat_len=3, stat_err=0.
- Bad checksum and single-symbol packet: a 1-symbol packet 0x05 with sop&eop -> stat_len=1, stat_err=0x1. Then a 3-symbol packet 0x01, 0x01, 0x01 -> stat_len=3, stat_err=0x1.
- Truncation: sop 0x7F, 0x01, then sop 0x00 and eop 0x00 on the next two symbols -> first record stat_len=2, stat_err=0x4; second record stat_len=2, stat_err=0.
- Orphans and too-long (MAX_LEN=4): 3 symbols without sop in IDLE -> orphan_cnt=3, no record. Then a 5-symbol packet with sum 0 -> stat_len=5, stat_err=0x2.
- FIFO full (STAT_DEPTH=4, stat_ready=0): 5 good packets -> 4 records held and stat_ovf=1. Then stat_ready=1 -> the 4 records drain in order and stat_valid=0 afterwards.
- Async reset: assert rst mid-packet and with records queued, off a clock edge -> outputs go to reset values before the next edge, and no stale record appears after release.
